// File: rtl/p_gen.sv
// p_gen: unary (thermometer) code generator.
// Accepts level commands and emits W-bit unary codes, optionally complimented,
// either as a single beat or as a one-level-per-beat ramp toward the target.
module p_gen #(
    parameter  int W                     = 16,
    parameter  int P_ADMIT_COMPLIMENT_EN = 1,
    localparam int LW                    = $clog2(W)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_cmd_vld,
    output logic          o_cmd_rdy,
    input  logic [LW-1:0] i_cmd_lvl,
    input  logic          i_cmd_cmpl,
    input  logic          i_cmd_ramp,
    output logic          o_cmd_err,
    output logic          o_out_vld,
    input  logic          i_out_rdy,
    output logic [W-1:0]  o_out_x,
    output logic          o_out_cmpl,
    output logic          o_out_last
);

    typedef enum logic {IDLE, RAMP} state_t;

    state_t        state;
    logic [LW-1:0] cur_lvl;
    logic [LW-1:0] tgt_lvl;
    logic          cmpl_q;

    logic          lvl_legal;
    logic          cmpl_eff;
    logic          out_free;
    logic          cmd_fire;
    logic [LW-1:0] idle_step;
    logic [LW-1:0] ramp_step;

    // k ones in the LSBs; k is always 1..W-1 here, so never all-zero or all-one
    function automatic logic [W-1:0] code_of(input logic [LW-1:0] k);
        return (W'(1) << k) - W'(1);
    endfunction

    function automatic logic [W-1:0] encode(input logic [LW-1:0] k, input logic c);
        return c ? ~code_of(k) : code_of(k);
    endfunction

    // One level toward the target; callers guarantee cur != tgt
    function automatic logic [LW-1:0] step_toward(input logic [LW-1:0] cur,
                                                  input logic [LW-1:0] tgt);
        return (tgt > cur) ? cur + LW'(1) : cur - LW'(1);
    endfunction

    // Command decode and next-level selection
    always_comb begin
        lvl_legal = (i_cmd_lvl != '0) && (32'(i_cmd_lvl) < 32'(W));
        cmpl_eff  = (P_ADMIT_COMPLIMENT_EN != 0) && i_cmd_cmpl;
        out_free  = ~o_out_vld | i_out_rdy;
        cmd_fire  = i_cmd_vld & o_cmd_rdy;
        idle_step = step_toward(cur_lvl, i_cmd_lvl);
        ramp_step = step_toward(cur_lvl, tgt_lvl);
    end

    // Commands are only taken in IDLE with the output register free to load
    assign o_cmd_rdy = (state == IDLE) & out_free;

    // FSM, level tracking and the registered output beat
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            cur_lvl    <= LW'(1);
            tgt_lvl    <= LW'(1);
            cmpl_q     <= 1'b0;
            o_out_vld  <= 1'b0;
            o_out_x    <= '0;
            o_out_cmpl <= 1'b0;
            o_out_last <= 1'b0;
            o_cmd_err  <= 1'b0;
        end else begin
            o_cmd_err <= 1'b0;
            // a transferred beat empties the register unless reloaded below
            if (o_out_vld && i_out_rdy) begin
                o_out_vld <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        if (!lvl_legal) begin
                            o_cmd_err <= 1'b1;
                        end else if (!i_cmd_ramp || (i_cmd_lvl == cur_lvl)) begin
                            o_out_vld  <= 1'b1;
                            o_out_x    <= encode(i_cmd_lvl, cmpl_eff);
                            o_out_cmpl <= cmpl_eff;
                            o_out_last <= 1'b1;
                            cur_lvl    <= i_cmd_lvl;
                        end else begin
                            tgt_lvl    <= i_cmd_lvl;
                            cmpl_q     <= cmpl_eff;
                            o_out_vld  <= 1'b1;
                            o_out_x    <= encode(idle_step, cmpl_eff);
                            o_out_cmpl <= cmpl_eff;
                            o_out_last <= (idle_step == i_cmd_lvl);
                            cur_lvl    <= idle_step;
                            if (idle_step != i_cmd_lvl) begin
                                state <= RAMP;
                            end
                        end
                    end
                end
                RAMP: begin
                    // the level advances when the next beat is loaded, not when sent
                    if (out_free) begin
                        o_out_vld  <= 1'b1;
                        o_out_x    <= encode(ramp_step, cmpl_q);
                        o_out_cmpl <= cmpl_q;
                        o_out_last <= (ramp_step == tgt_lvl);
                        cur_lvl    <= ramp_step;
                        if (ramp_step == tgt_lvl) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
